// File: rtl/tt_pkg.sv
// tt_pkg: shared state encoding and sizing for the truth-table sweeper
package tt_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
    localparam int NUM_VECTORS = 8;
    localparam int VEC_W = 3;
    localparam int CNT_W = 4;
endpackage

// File: rtl/tt_settle_timer.sv
// tt_settle_timer: settle down-counter, loaded on entry to SETTLE, flags zero on the last hold cycle
module tt_settle_timer
    import tt_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic zero
);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES == 0 ? 0 : SETTLE_CYCLES - 1);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= LOAD_VAL;
        else if (count && cnt != '0) cnt <= cnt - 1'b1;
    end
    assign zero = cnt == '0;
endmodule

// File: rtl/tt_sweep.sv
// tt_sweep: drives all 8 input vectors into a 3-input DUT, captures its truth table and compares it
module tt_sweep
    import tt_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] expected,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       d,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] truth_table,
    output logic [7:0] mismatch
);
    localparam state_t FIRST = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
    state_t state;
    logic [VEC_W-1:0] vector;
    logic [7:0] exp_q;
    logic load, zero, last;
    assign last = vector == VEC_W'(NUM_VECTORS - 1);
    assign load = (state == IDLE && start) || (state == SAMPLE && !last);
    assign {a, b, c} = vector;
    tt_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk(clk),
        .rst(rst),
        .load(load),
        .count(state == SETTLE),
        .zero(zero)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            vector <= '0;
            exp_q <= '0;
            truth_table <= '0;
            mismatch <= '0;
            pass <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= FIRST;
                    vector <= '0;
                    truth_table <= '0;
                    exp_q <= expected;
                    busy <= 1'b1;
                end
                SETTLE: if (zero) state <= SAMPLE;
                SAMPLE: begin
                    truth_table[vector] <= d;
                    if (last) state <= DONE;
                    else begin
                        vector <= vector + 1'b1;
                        state <= FIRST;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    pass <= truth_table == exp_q;
                    mismatch <= truth_table ^ exp_q;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/tt_sweep.md
TT_SWEEP -- requirements
Module: tt_sweep

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning the cycles each vector is held before the DUT output is sampled (legal range 0..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: requests one sweep; sampled only in IDLE.
REQ-005 SHALL have port expected, input, 8 bits: the expected truth table; bit i is the expected d for vector i = {a,b,c}.
REQ-006 SHALL have ports a, b, c, output, 1 bit each: stimulus to the 3-input DUT; a is the MSB of the vector index.
REQ-007 SHALL have port d, input, 1 bit: the DUT response.
REQ-008 SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking the end of a sweep.
REQ-010 SHALL have port pass, output, 1 bit: result of the last sweep, valid from done onward.
REQ-011 SHALL have port table, output, 8 bits: captured truth table; bit i is d sampled for vector i.
REQ-012 SHALL have port mismatch, output, 8 bits: table XOR the latched expected value, updated at done.

Function
REQ-013 SHALL implement FSM states IDLE, SETTLE, SAMPLE and DONE.
REQ-014 SHALL transition IDLE->SETTLE when start=1, which also: sets vector=0, clears table, latches expected, and sets busy=1.
REQ-015 SHALL hold {a,b,c}=vector stable for SETTLE_CYCLES cycles in SETTLE, then move to SAMPLE; SETTLE_CYCLES=0 goes directly to SAMPLE.
REQ-016 SHALL, in SAMPLE, write d into table[vector], and:
- if vector=7, go to DONE;
- otherwise increment vector and go to SETTLE.
REQ-017 SHALL spend exactly SETTLE_CYCLES+1 cycles per vector; done rises 8*(SETTLE_CYCLES+1)+1 cycles after the edge that accepted start (default: cycle 25).
REQ-018 SHALL, in DONE, for one cycle:
- assert done=1 and busy=0;
- register pass=(table==expected_latched) and mismatch=table^expected_latched;
- then return to IDLE.
REQ-019 SHALL ignore start while busy=1 or in DONE; no restart and no queued request.
REQ-020 SHALL accept start high in the IDLE cycle right after DONE, giving back-to-back sweeps.
REQ-021 SHALL keep table, pass and mismatch unchanged in IDLE until the next accepted start; table clears on start, pass and mismatch hold until the next DONE.
REQ-022 SHALL wrap vector only via IDLE; vector never exceeds 7.
REQ-023 SHALL not let changes on the expected port after start affect the current sweep.

Reset
REQ-024 SHALL, with rst=1 at an edge, force state=IDLE, vector=0, {a,b,c}=000, table=0, mismatch=0, pass=0, busy=0, done=0.
REQ-025 SHALL let rst override start in the same cycle.
REQ-026 SHALL, on reset mid-sweep, abort the sweep with no done pulse and no partial table retained.

Structure
REQ-027 SHALL place in shared package tt_pkg: the state enum, NUM_VECTORS=8 and VEC_W=3.
REQ-028 SHALL place the settle down-counter in sub-module tt_settle_timer (load, count, zero flag).

Verification
REQ-029 SHALL cover: DUT=3-input majority, expected=8'hE8, start pulse -> done at cycle 25, table=8'hE8, pass=1, mismatch=8'h00.
REQ-030 SHALL cover: DUT=AND3, expected=8'h81 -> table=8'h80, pass=0, mismatch=8'h01.
REQ-031 SHALL cover: start held high for the whole sweep -> exactly one done per sweep, back-to-back sweep begins the cycle after DONE returns to IDLE.
REQ-032 SHALL cover: rst asserted at vector 4 -> outputs at reset values the next cycle, no done, a fresh start gives a full correct sweep.
REQ-033 SHALL cover: SETTLE_CYCLES=0 with DUT=XOR3, expected=8'h96 -> done at cycle 9, pass=1.
REQ-034 SHALL cover: expected changed to 8'h00 mid-sweep with majority DUT and expected latched as 8'hE8 -> pass=1.
